// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: sequencer states and default Q-format constants.
package neuron_pkg;

    localparam int unsigned WeightWidth = 16;
    localparam int unsigned FracBits    = 8;

    localparam logic signed [WeightWidth-1:0] SatMax = 16'sh7fff;
    localparam logic signed [WeightWidth-1:0] SatMin = 16'sh8000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StOut
    } state_e;

endpackage

// File: rtl/sat_relu.sv
// Converts a wide fixed-point accumulator to a saturated output word, with optional ReLU.
module sat_relu
    import neuron_pkg::*;
#(
    parameter int unsigned accWidth    = 40,
    parameter int unsigned weightWidth = WeightWidth,
    parameter int unsigned fracBits    = FracBits
) (
    input  logic signed [accWidth-1:0]    acc,
    input  logic                          relu_en,
    output logic signed [weightWidth-1:0] result
);

    // Output limits expressed at accumulator width so the compare needs no truncation.
    localparam logic signed [accWidth-1:0] HiLim =
        {{(accWidth-weightWidth+1){1'b0}}, {(weightWidth-1){1'b1}}};
    localparam logic signed [accWidth-1:0] LoLim =
        {{(accWidth-weightWidth+1){1'b1}}, {(weightWidth-1){1'b0}}};
    localparam logic signed [weightWidth-1:0] OutMax = {1'b0, {(weightWidth-1){1'b1}}};
    localparam logic signed [weightWidth-1:0] OutMin = {1'b1, {(weightWidth-1){1'b0}}};

    logic signed [accWidth-1:0]    shifted;
    logic signed [weightWidth-1:0] sat;

    assign shifted = acc >>> fracBits;

    always_comb begin
        sat = shifted[weightWidth-1:0];
        if (shifted > HiLim) begin
            sat = OutMax;
        end else if (shifted < LoLim) begin
            sat = OutMin;
        end
    end

    assign result = (relu_en && sat[weightWidth-1]) ? '0 : sat;

endmodule

// File: rtl/neuron_mac_seq.sv
// Sweeps the weight memory, accumulates weight*activation on top of a bias and emits one
// saturated neuron output per start.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int unsigned inWidth     = 121,
    parameter int unsigned weightWidth = WeightWidth,
    parameter int unsigned memoryDepth = 7,
    parameter int unsigned fracBits    = FracBits,
    parameter int unsigned accWidth    = 40
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [weightWidth-1:0] bias,
    input  logic                   relu_en,
    output logic [memoryDepth-1:0] mem_address,
    output logic                   mem_write_enable,
    input  logic [weightWidth-1:0] mem_data_out,
    input  logic [weightWidth-1:0] act_data,
    output logic                   busy,
    output logic [weightWidth-1:0] result,
    output logic                   result_valid
);

    localparam logic [memoryDepth-1:0] LastAddr = memoryDepth'(inWidth - 1);
    localparam int unsigned ProdWidth = 2 * weightWidth;

    state_e                   state_q, state_d;
    logic [memoryDepth-1:0]   addr_q, addr_d;
    logic                     rd_valid_q;
    logic signed [accWidth-1:0] acc_q, acc_d;
    logic                     relu_q, relu_d;
    logic [weightWidth-1:0]   result_q, result_d;
    logic                     result_valid_q, result_valid_d;

    logic signed [ProdWidth-1:0]   prod;
    logic signed [accWidth-1:0]    prod_ext;
    logic signed [accWidth-1:0]    bias_ext;
    logic signed [weightWidth-1:0] sat_out;

    assign prod     = $signed(mem_data_out) * $signed(act_data);
    assign prod_ext = {{(accWidth-ProdWidth){prod[ProdWidth-1]}}, prod};
    assign bias_ext = {{(accWidth-weightWidth){bias[weightWidth-1]}}, bias};

    sat_relu #(
        .accWidth    (accWidth),
        .weightWidth (weightWidth),
        .fracBits    (fracBits)
    ) u_sat_relu (
        .acc     (acc_q),
        .relu_en (relu_q),
        .result  (sat_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (addr_q == LastAddr) state_d = StDrain;
            StDrain: state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d         = addr_q;
        acc_d          = acc_q;
        relu_d         = relu_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                addr_d = '0;
                if (start) begin
                    acc_d  = bias_ext <<< fracBits;
                    relu_d = relu_en;
                end
            end
            StIssue: begin
                if (addr_q != LastAddr) addr_d = addr_q + 1'b1;
            end
            StDrain: ;
            StOut: begin
                addr_d         = '0;
                result_d       = sat_out;
                result_valid_d = 1'b1;
            end
            default: ;
        endcase
        // Data for the address issued on the previous edge is on the bus now.
        if (rd_valid_q) acc_d = acc_q + prod_ext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q         <= '0;
            rd_valid_q     <= 1'b0;
            acc_q          <= '0;
            relu_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            rd_valid_q     <= (state_q == StIssue);
            acc_q          <= acc_d;
            relu_q         <= relu_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign mem_address      = addr_q;
    assign mem_write_enable = 1'b0;
    assign busy             = (state_q != StIdle);
    assign result           = result_q;
    assign result_valid     = result_valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed-vector bench for neuron_mac_seq with a registered weight/activation memory model.
module tb_neuron_mac_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bias = '0;
    logic        relu_en = 1'b0;
    logic [6:0]  mem_address;
    logic        mem_write_enable;
    logic [15:0] mem_data_out = '0;
    logic [15:0] act_data = '0;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;

    logic [15:0] wmem [128];
    logic [15:0] amem [128];

    int n_checks = 0;
    int n_errors = 0;

    neuron_mac_seq dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .bias             (bias),
        .relu_en          (relu_en),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out),
        .act_data         (act_data),
        .busy             (busy),
        .result           (result),
        .result_valid     (result_valid)
    );

    always #5 clk = ~clk;

    // One-cycle read latency, like the real weight memory.
    always @(posedge clk) begin
        mem_data_out <= wmem[mem_address];
        act_data     <= amem[mem_address];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int wv, input int av, input bit ramp);
        for (int i = 0; i < 128; i++) begin
            wmem[i] = ramp ? 16'(i) : 16'(wv);
            amem[i] = 16'(av);
        end
    endtask

    // Launches one evaluation; lat counts edges after the start edge until result_valid.
    task automatic run_eval(input int b, input bit r, output int lat, output bit sweep_ok);
        int exp_addr;
        @(negedge clk);
        bias    = 16'(b);
        relu_en = r;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        sweep_ok = (mem_address == 7'd0) && busy;
        while (!result_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            exp_addr = (lat >= 123) ? 0 : ((lat > 120) ? 120 : lat);
            if (int'(mem_address) != exp_addr) sweep_ok = 1'b0;
        end
    endtask

    int lat;
    bit sweep_ok;
    int prev;
    bit hold_ok;
    bit seen;
    int n;

    initial begin
        fill(0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr", int'(mem_address), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_result", int'(result), 0);
        check("reset_valid", int'(result_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;

        fill(256, 256, 1'b0);
        run_eval(0, 1'b0, lat, sweep_ok);
        check("unit_latency", lat, 123);
        check("unit_result", $signed(result), 30976);
        check("unit_sweep", int'(sweep_ok), 1);
        check("write_enable", int'(mem_write_enable), 0);
        @(posedge clk);
        #1;
        check("pulse_one_cycle", int'(result_valid), 0);
        check("busy_after", int'(busy), 0);
        check("result_hold", $signed(result), 30976);

        fill(256, 512, 1'b0);
        run_eval(0, 1'b0, lat, sweep_ok);
        check("sat_pos", $signed(result), 32767);

        fill(-256, 512, 1'b0);
        run_eval(0, 1'b0, lat, sweep_ok);
        check("sat_neg", $signed(result), -32768);

        fill(-256, 256, 1'b0);
        run_eval(0, 1'b0, lat, sweep_ok);
        check("neg_norelu", $signed(result), -30976);
        run_eval(0, 1'b1, lat, sweep_ok);
        check("neg_relu", $signed(result), 0);

        fill(0, 256, 1'b0);
        run_eval(1280, 1'b0, lat, sweep_ok);
        check("bias_only", $signed(result), 1280);

        fill(0, 256, 1'b1);
        run_eval(0, 1'b0, lat, sweep_ok);
        check("ramp_sum", $signed(result), 7260);

        // -121/256 must floor to -1, not truncate to 0.
        fill(-1, 1, 1'b0);
        run_eval(0, 1'b0, lat, sweep_ok);
        check("floor_shift", $signed(result), -1);

        // start held high: ignored while busy, accepted again on the result_valid cycle.
        fill(256, 256, 1'b0);
        @(negedge clk);
        bias    = '0;
        relu_en = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!result_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_latency", lat, 123);
        check("held_result", $signed(result), 30976);
        prev = $signed(result);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held_restart_busy", int'(busy), 1);
        check("held_pulse_len", int'(result_valid), 0);
        lat     = 0;
        hold_ok = 1'b1;
        while (!result_valid && lat < 300) begin
            if ($signed(result) != prev) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_second_latency", lat, 123);
        check("held_result_stable", int'(hold_ok), 1);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (mem_address != 7'd50 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_addr_reached", int'(mem_address), 50);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_addr", int'(mem_address), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_result", int'(result), 0);
        check("rst_async_valid", int'(result_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (130) begin
            @(posedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        check("rst_no_valid", int'(seen), 0);
        run_eval(0, 1'b0, lat, sweep_ok);
        check("rst_recover_latency", lat, 123);
        check("rst_recover_result", $signed(result), 30976);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
Sequencer and multiply-accumulate stage sitting directly downstream of the weight memory. On start it sweeps the memory address from 0 to inWidth-1 and reads one weight per cycle from the registered memory output. Each weight is multiplied by the aligned activation word, and the products are accumulated on top of a bias. The block emits one saturated fixed-point neuron output, with optional ReLU applied.

Parameters:
inWidth, 121, number of weight/activation pairs per neuron (memory words swept)
weightWidth, 16, signed fixed-point word width of weights, activations, bias and result
memoryDepth, 7, address width; must satisfy 2^memoryDepth >= inWidth
fracBits, 8, fractional bits of the Q format (1.0 = 2^fracBits)
accWidth, 40, accumulator width; must be >= 2*weightWidth + memoryDepth + 1

Ports:
clk  input  1  rising-edge clock, single clock domain
reset_n  input  1  asynchronous, active-low reset
start  input  1  request one neuron evaluation; sampled only in IDLE
bias  input  weightWidth  signed bias, sampled on the start edge
relu_en  input  1  apply ReLU to the result; sampled on the start edge
mem_address  output  memoryDepth  read address to the weight memory and the activation source
mem_write_enable  output  1  write enable to the weight memory; constant 0 from this block
mem_data_out  input  weightWidth  signed weight, valid 1 cycle after mem_address
act_data  input  weightWidth  signed activation, same 1-cycle latency and alignment as mem_data_out
busy  output  1  high from the start edge until result_valid is asserted
result  output  weightWidth  signed saturated neuron output; held until the next result
result_valid  output  1  one-cycle pulse when result is updated

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; mem_address=0, busy=0, result=0, result_valid=0.
- Reset also clears the accumulator, issue counter and read-valid pipe.
- Reset mid-operation aborts the sweep; no result_valid is produced for the aborted evaluation.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: on edge E0 with start=1:
  - busy<=1, mem_address<=0, state<=ISSUE
  - acc<=sign_ext(bias)<<fracBits
  - latch relu_en
- IDLE: start=0 -> stay in IDLE.
- ISSUE: mem_address increments by 1 each edge.
  - A 1-bit read-valid flag follows the issued address by one edge.
  - When mem_address=inWidth-1 has been issued, state<=DRAIN and mem_address holds at inWidth-1 (no wrap to 0 during an operation).
- Accumulate: at edge E(k+2), acc += mem_data_out * act_data for word k.
  - Product is full 2*weightWidth signed, sign-extended to accWidth.
  - Last product (k=inWidth-1) is accumulated at E(inWidth+1); DRAIN covers that edge, then state<=OUT.
- OUT, at edge E(inWidth+2):
  - Compute r = acc >>> fracBits (arithmetic shift, floor).
  - Saturate r to [-2^(weightWidth-1), 2^(weightWidth-1)-1].
  - If the latched relu_en=1 and r<0, r=0.
  - result<=r, result_valid<=1 for exactly one cycle, busy<=0, state<=IDLE, mem_address<=0.
- Latency: result_valid is high in the cycle after E(inWidth+2); default inWidth=121 gives 123 edges after the start edge.
- start while busy: ignored, with no queuing.
- start in the same cycle result_valid is high: accepted, since state is already IDLE. Back-to-back evaluations are therefore spaced inWidth+3 cycles.
- The accumulator never wraps within the stated accWidth constraint; saturation happens only at the output.

Decomposition:
- Shared package neuron_pkg holds:
  - the state encoding (IDLE/ISSUE/DRAIN/OUT)
  - the default Q-format constants (fracBits, weightWidth)
  - the saturation min/max constants
- One sub-module: sat_relu (combinational shift, saturate and ReLU, parameterised by accWidth/weightWidth/fracBits), reused by later layers.
- Sequencer, counter and accumulator stay in neuron_mac_seq.

Test Plan:
- Weights all 256 (1.0), acts all 256, bias 0, relu_en=0 -> result=30976 (121.0); result_valid pulse exactly 123 edges after the start edge; mem_address sweeps 0..120.
- Weights 256, acts 512 (2.0) -> true value 242.0 overflows -> result=32767. Weights -256, acts 512 -> result=-32768.
- Weights -256, acts 256, bias 0: relu_en=0 -> result=-30976; relu_en=1 -> result=0.
- Weights 0, bias 1280 (5.0) -> result=1280. Weight[k]=k, acts 256 -> result=sum(0..120)=7260.
- start held high across an evaluation -> only one busy period per accepted start; the next evaluation begins on the edge where result_valid is high; the result is unchanged between pulses.
- reset_n pulsed low when mem_address=50 -> all outputs 0 immediately (asynchronous); no result_valid; a subsequent start produces a correct full result.
